// File: rtl/bp_io_cmd_arbiter_if.sv
// Requester-side and link-side bundle for bp_io_cmd_arbiter.
// slave is the arbiter's view; master is the view of whoever drives the requesters and the link.
interface bp_io_cmd_arbiter_if #(
    parameter int num_req_p   = 2,
    parameter int msg_width_p = 64
);
    logic [num_req_p*msg_width_p-1:0] cmd_i;
    logic [num_req_p-1:0]             cmd_v_i;
    logic [num_req_p-1:0]             cmd_ready_and_o;
    logic [msg_width_p-1:0]           io_cmd_o;
    logic                             io_cmd_v_o;
    logic                             io_cmd_ready_and_i;
    logic [msg_width_p-1:0]           io_resp_i;
    logic                             io_resp_v_i;
    logic                             io_resp_yumi_o;
    logic [msg_width_p-1:0]           resp_o;
    logic [num_req_p-1:0]             resp_v_o;
    logic [num_req_p-1:0]             resp_yumi_i;

    modport slave (
        input  cmd_i, cmd_v_i, io_cmd_ready_and_i, io_resp_i, io_resp_v_i, resp_yumi_i,
        output cmd_ready_and_o, io_cmd_o, io_cmd_v_o, io_resp_yumi_o, resp_o, resp_v_o
    );

    modport master (
        output cmd_i, cmd_v_i, io_cmd_ready_and_i, io_resp_i, io_resp_v_i, resp_yumi_i,
        input  cmd_ready_and_o, io_cmd_o, io_cmd_v_o, io_resp_yumi_o, resp_o, resp_v_o
    );
endinterface

// File: rtl/bp_io_cmd_arbiter.sv
// Round-robin, credit-limited command arbiter with in-order response steering via a source-ID FIFO.
// Optional watchdog enabled by defining BP_IO_CMD_ARB_TIMEOUT_EN.
module bp_io_cmd_arbiter #(
    parameter int num_req_p         = 2,
    parameter int msg_width_p       = 64,
    parameter int max_outstanding_p = 4,
    parameter int timeout_p         = 1024
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    bp_io_cmd_arbiter_if.slave                     bus,
    output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
    output logic                                   error_o,
    output logic                                   timeout_o
);
    localparam int id_w_lp  = $clog2(num_req_p);
    localparam int cnt_w_lp = $clog2(max_outstanding_p+1);
    localparam int ptr_w_lp = $clog2(max_outstanding_p);
    localparam logic [cnt_w_lp-1:0] max_lp  = cnt_w_lp'(max_outstanding_p);
    localparam logic [id_w_lp-1:0]  last_lp = id_w_lp'(num_req_p-1);

    logic [id_w_lp-1:0]  rr_q, grant, head;
    logic [cnt_w_lp-1:0] cnt_q;
    logic [ptr_w_lp-1:0] wr_q, rd_q;
    logic [id_w_lp-1:0]  fifo_q [max_outstanding_p];
    logic                credit_ok, any_v, push, pop, nonempty, err_q;

    assign credit_ok = (cnt_q < max_lp);
    assign any_v     = |bus.cmd_v_i;
    assign nonempty  = (cnt_q != '0);
    assign head      = fifo_q[rd_q];

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        int   idx;
        logic found;
        grant = rr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= num_req_p) idx = idx - num_req_p;
            if (!found && bus.cmd_v_i[idx]) begin
                grant = id_w_lp'(idx);
                found = 1'b1;
            end
        end
    end

    // Every output is forced low while reset is asserted, including the pass-through paths.
    always_comb begin
        bus.cmd_ready_and_o = '0;
        bus.resp_v_o        = '0;
        bus.io_cmd_o        = '0;
        bus.resp_o          = '0;
        bus.io_cmd_v_o      = 1'b0;
        bus.io_resp_yumi_o  = 1'b0;
        if (reset_n_i) begin
            bus.io_cmd_o   = bus.cmd_i[grant*msg_width_p +: msg_width_p];
            bus.io_cmd_v_o = any_v & credit_ok;
            if (any_v && credit_ok && bus.io_cmd_ready_and_i)
                bus.cmd_ready_and_o[grant] = 1'b1;
            bus.resp_o = bus.io_resp_i;
            if (nonempty) begin
                bus.resp_v_o[head] = bus.io_resp_v_i;
                bus.io_resp_yumi_o = bus.io_resp_v_i & bus.resp_yumi_i[head];
            end else begin
                bus.io_resp_yumi_o = bus.io_resp_v_i;
            end
        end
    end

    assign push = bus.io_cmd_v_o & bus.io_cmd_ready_and_i;
    assign pop  = nonempty & bus.io_resp_v_i & bus.resp_yumi_i[head];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_q  <= '0;
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (push) begin
                rr_q <= (grant == last_lp) ? '0 : grant + id_w_lp'(1);
                wr_q <= wr_q + ptr_w_lp'(1);
            end
            if (pop) rd_q <= rd_q + ptr_w_lp'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + cnt_w_lp'(1);
                2'b01:   cnt_q <= cnt_q - cnt_w_lp'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (bus.io_resp_v_i && !nonempty) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_q] <= grant;
    end

    assign outstanding_o = cnt_q;
    assign error_o       = err_q;

`ifdef BP_IO_CMD_ARB_TIMEOUT_EN
    localparam int wd_w_lp = $clog2(timeout_p+1);
    localparam logic [wd_w_lp-1:0] lim_lp = wd_w_lp'(timeout_p);

    logic [wd_w_lp-1:0] wd_q;
    logic               to_q;

    // Flag is raised on the same edge the counter reaches the limit.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else if (!nonempty || pop) begin
            wd_q <= '0;
        end else begin
            if (wd_q != lim_lp) wd_q <= wd_q + wd_w_lp'(1);
            if (wd_q >= lim_lp - wd_w_lp'(1)) to_q <= 1'b1;
        end
    end

    assign timeout_o = to_q;
`else
    assign timeout_o = 1'b0;
`endif
endmodule

// File: doc/bp_io_cmd_arbiter.md
Name: bp_io_cmd_arbiter

Overview:
Shares one IO-NoC command/response port pair among num_req_p BedRock memory-message sources, for example a CCE path and a DMA/debug master feeding the IO tile's cce-to-mem link.
- Commands: round-robin arbitration, gated by a credit limit on total outstanding requests.
- Responses: returned in order, each steered to the requester that issued it, using a source-ID FIFO.
- Placement: sits between the requesters and the link's mem_cmd/mem_resp side.

Parameters:
num_req_p, 2, number of requesters (2..8)
msg_width_p, 64, width of one bp_bedrock_cce_mem_msg_s (header plus data), set by the instantiating tile
max_outstanding_p, 4, maximum commands issued without a response (power of 2, 2..16); also the source-ID FIFO depth
timeout_p, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
cmd_i  in  num_req_p*msg_width_p  requester commands; slice r belongs to requester r
cmd_v_i  in  num_req_p  per-requester command valid
cmd_ready_and_o  out  num_req_p  per-requester ready; a transfer occurs when v&ready
io_cmd_o  out  msg_width_p  arbitrated command toward the link
io_cmd_v_o  out  1  command valid
io_cmd_ready_and_i  in  1  link ready (ready-and)
io_resp_i  in  msg_width_p  response from the link
io_resp_v_i  in  1  response valid
io_resp_yumi_o  out  1  response consumed (valid-yumi)
resp_o  out  msg_width_p  io_resp_i broadcast to all requesters
resp_v_o  out  num_req_p  one-hot response valid for the owning requester
resp_yumi_i  in  num_req_p  per-requester response consume
outstanding_o  out  $clog2(max_outstanding_p+1)  current number of outstanding commands
error_o  out  1  sticky: a response arrived while nothing was outstanding
timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (reset_n_i low, asynchronous): rr pointer=0, FIFO empty, outstanding=0, error_o=0, timeout_o=0, watchdog counter=0. All outputs are 0 during reset.
- credit_ok = (registered count < max_outstanding_p). No same-cycle pop-to-push bypass: at full, a pop this cycle frees a credit only in the next cycle.
- Grant (combinational):
  - The highest-priority requester with cmd_v_i set wins, searching from the rr pointer upward with wrap-around.
  - The grant is computed only from cmd_v_i and the pointer.
- Command outputs:
  - io_cmd_o = cmd_i slice of the grant.
  - io_cmd_v_o = |cmd_v_i & credit_ok. It never depends on io_cmd_ready_and_i.
  - cmd_ready_and_o[g] = io_cmd_ready_and_i & credit_ok for the granted requester only; all other bits are 0.
- Command handshake (io_cmd_v_o & io_cmd_ready_and_i):
  - Push grant ID into the FIFO; count increments.
  - rr pointer <= (grant+1) mod num_req_p.
  - The pointer holds when no handshake occurs.
- Response steering:
  - head = FIFO head ID.
  - When the FIFO is non-empty: resp_v_o = io_resp_v_i << head and io_resp_yumi_o = resp_yumi_i[head]. Yumi on a non-head bit is ignored.
  - A yumi pops the FIFO; count decrements.
- Simultaneous push and pop: count is unchanged; FIFO pointers both advance.
- Empty-FIFO response: io_resp_yumi_o=1 (drain), resp_v_o=0, error_o set sticky until reset.
- Latency: command is combinational pass-through (0 cycles). Response is combinational to the owning requester.
- Ordering: the link returns responses in order; the block relies on this, and it is a block requirement.
- outstanding_o reflects the registered count.

Optional Feature:
BP_IO_CMD_ARB_TIMEOUT_EN
- Defined: a watchdog counter increments every cycle while count>0 and no response handshake occurs.
  - It clears on any response handshake and when count==0.
  - Reaching timeout_p sets timeout_o, sticky until reset; the counter saturates.
  - Arbitration is unaffected.
- Undefined: no counter logic; timeout_o tied 0.

Test Plan:
- Round robin: both requesters valid continuously, io_cmd_ready_and_i=1, responses returned immediately -> io_cmd grants alternate 0,1,0,1; each requester sees only its own responses.
- Credit stall: 4 commands issued with no responses (max_outstanding_p=4) -> outstanding_o=4 and io_cmd_v_o=0 while cmd_v_i=2'b11. One response yumi -> outstanding_o=3 the next cycle, and io_cmd_v_o=1 that cycle, not the same cycle.
- Backpressure: io_cmd_ready_and_i=0 for 5 cycles with req1 valid -> io_cmd_v_o stays 1, cmd_ready_and_o=0, rr pointer and count unchanged.
- Steering: issue order req1, req0, req1 -> resp_v_o sequence 2'b10, 2'b01, 2'b10. Stray yumi on a non-head bit does not pop.
- Error: io_resp_v_i=1 with count=0 -> io_resp_yumi_o=1, resp_v_o=0, error_o=1 persisting. Async reset mid-traffic -> all state 0 immediately, without waiting for a clock edge.
- Timeout (macro defined, timeout_p=16): 1 outstanding, no response for 16 cycles -> timeout_o=1. Macro undefined -> timeout_o=0.
